// File: rtl/mtl_frame_fetch.sv
// mtl_frame_fetch: burst prefetch of one display frame from SDRAM into a pixel FIFO for the MTL controller
module mtl_frame_fetch #(
  parameter int FIFO_DEPTH  = 64,
  parameter int BURST_LEN   = 16,
  parameter int FRAME_WORDS = 384000,
  parameter int PRIME_LEVEL = 32,
  parameter int ADDR_W      = 25
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              newframe,
  input  logic [ADDR_W-1:0] frame_base,
  input  logic              read_sdram_en,
  output logic [31:0]       read_data,
  output logic              loading,
  output logic              underflow,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(BURST_LEN);
  localparam int WW = $clog2(FRAME_WORDS + 1);
  typedef enum logic [2:0] {IDLE, REQ, DATA, FLUSH, DONE} state_t;
  state_t state, nxt;
  logic [ADDR_W-1:0] base;
  logic [WW-1:0] words;
  logic [BW-1:0] beat;
  logic [31:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic in_burst, last_beat, accepted, outstanding, wr, pop, space;
  always_comb begin
    in_burst    = state == DATA || state == FLUSH;
    last_beat   = in_burst && mem_rvalid && beat == BW'(BURST_LEN - 1);
    accepted    = state == REQ && mem_req && mem_ack;
    outstanding = (in_burst && !last_beat) || accepted;
    wr          = state == DATA && mem_rvalid && !newframe;
    pop         = read_sdram_en && count != '0 && !newframe;
    space       = count <= CW'(FIFO_DEPTH - BURST_LEN);
    nxt = newframe ? (outstanding ? FLUSH : REQ)
        : accepted ? DATA
        : last_beat ? ((state == FLUSH || words < WW'(FRAME_WORDS)) ? REQ : DONE)
        : state;
  end
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= mem_rdata;
  always_ff @(posedge clk) begin
    if (reset) begin
      base      <= '0;
      words     <= '0;
      beat      <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      read_data <= '0;
      loading   <= 1'b1;
      underflow <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
    end else begin
      if (in_burst && mem_rvalid) beat <= beat + 1'b1;
      if (newframe) begin
        base      <= frame_base;
        words     <= '0;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        count     <= '0;
        underflow <= read_sdram_en;
        loading   <= 1'b1;
        mem_req   <= !outstanding;
        mem_addr  <= frame_base;
      end else begin
        if (wr) wr_ptr <= wr_ptr + 1'b1;
        if (pop) begin
          rd_ptr    <= rd_ptr + 1'b1;
          read_data <= mem[rd_ptr];
        end
        count <= count + CW'(wr) - CW'(pop);
        if (read_sdram_en && count == '0) underflow <= 1'b1;
        if (count >= CW'(PRIME_LEVEL)) loading <= 1'b0;
        if (state == REQ) begin
          if (mem_req) begin
            if (mem_ack) begin
              mem_req <= 1'b0;
              words   <= words + WW'(BURST_LEN);
            end
          end else begin
            mem_req  <= space;
            mem_addr <= base + ADDR_W'(words);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_mtl_frame_fetch.sv
// tb_mtl_frame_fetch: directed scenario bench with a one-burst-outstanding SDRAM responder
module tb_mtl_frame_fetch;
  logic clk = 1'b0;
  logic reset, newframe, read_sdram_en;
  logic [24:0] frame_base;
  logic [31:0] read_data;
  logic loading, underflow, mem_req, mem_ack, mem_rvalid;
  logic [24:0] mem_addr;
  logic [31:0] mem_rdata;
  int n_cmp = 0;
  int n_fail = 0;
  int beats_left = 0;
  int beats_done = 0;
  int next_data = 0;
  int hi;
  logic acc, bt;
  logic [24:0] addr_s;
  logic [24:0] req_q[$];
  logic [31:0] held;
  always #5 clk = ~clk;
  assign mem_ack = mem_req;
  mtl_frame_fetch #(.FRAME_WORDS(128)) dut (
    .clk(clk), .reset(reset), .newframe(newframe), .frame_base(frame_base),
    .read_sdram_en(read_sdram_en), .read_data(read_data), .loading(loading),
    .underflow(underflow), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );
  initial begin
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      acc = mem_req && mem_ack;
      bt = mem_rvalid;
      addr_s = mem_addr;
      @(posedge clk);
      #1;
      if (bt) begin
        beats_left--;
        beats_done++;
        next_data++;
      end
      if (acc) begin
        req_q.push_back(addr_s);
        beats_left = 16;
      end
      mem_rvalid = beats_left > 0;
      mem_rdata = 32'(next_data);
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    n_cmp++; if (loading !== 1'b1) begin n_fail++; $display("FAIL reset_loading: got %b want 1", loading); end
    n_cmp++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL reset_underflow: got %b want 0", underflow); end
    n_cmp++; if (read_data !== 32'h0) begin n_fail++; $display("FAIL reset_read_data: got %h want 0", read_data); end
    n_cmp++; if (mem_addr !== 25'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    reset = 1'b0;
    hi = 0;
    repeat (6) begin step(); if (mem_req) hi++; end
    n_cmp++; if (hi !== 0) begin n_fail++; $display("FAIL idle_no_req: got %0d req cycles want 0", hi); end
    n_cmp++; if (req_q.size() !== 0) begin n_fail++; $display("FAIL idle_no_accept: got %0d want 0", req_q.size()); end
  endtask
  task automatic test_prime();
    next_data = 0;
    beats_done = 0;
    frame_base = 25'h1000;
    newframe = 1'b1;
    step();
    newframe = 1'b0;
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 25'h1000) begin n_fail++; $display("FAIL prime_first_req: got %b/%h want 1/1000", mem_req, mem_addr); end
    for (int k = 0; k < 300 && beats_done < 32; k++) step();
    n_cmp++; if (beats_done !== 32) begin n_fail++; $display("FAIL prime_32_beats: got %0d want 32", beats_done); end
    n_cmp++; if (loading !== 1'b1) begin n_fail++; $display("FAIL prime_loading_at_32: got %b want 1", loading); end
    step();
    n_cmp++; if (loading !== 1'b0) begin n_fail++; $display("FAIL prime_loading_after_32: got %b want 0", loading); end
    for (int k = 0; k < 300 && beats_done < 64; k++) step();
    n_cmp++; if (beats_done !== 64) begin n_fail++; $display("FAIL prime_64_beats: got %0d want 64", beats_done); end
    hi = 0;
    repeat (20) begin step(); if (mem_req) hi++; end
    n_cmp++; if (hi !== 0) begin n_fail++; $display("FAIL prime_full_no_req: got %0d req cycles want 0", hi); end
    n_cmp++; if (req_q.size() !== 4) begin n_fail++; $display("FAIL prime_req_count: got %0d want 4", req_q.size()); end
    for (int i = 0; i < 4 && i < req_q.size(); i++) begin
      n_cmp++; if (req_q[i] !== 25'h1000 + 25'(16 * i)) begin n_fail++; $display("FAIL prime_addr%0d: got %h want %h", i, req_q[i], 25'h1000 + 25'(16 * i)); end
    end
    n_cmp++; if (loading !== 1'b0) begin n_fail++; $display("FAIL prime_loading_sticky: got %b want 0", loading); end
  endtask
  task automatic test_ordering();
    for (int i = 0; i < 64; i++) begin
      read_sdram_en = 1'b1;
      step();
      n_cmp++; if (read_data !== 32'(i)) begin n_fail++; $display("FAIL order_word%0d: got %0d want %0d", i, read_data, i); end
    end
    read_sdram_en = 1'b0;
    n_cmp++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL order_underflow: got %b want 0", underflow); end
  endtask
  task automatic test_frame_end();
    for (int i = 64; i < 128; i++) begin
      read_sdram_en = 1'b1;
      step();
      read_sdram_en = 1'b0;
      n_cmp++; if (read_data !== 32'(i)) begin n_fail++; $display("FAIL end_word%0d: got %0d want %0d", i, read_data, i); end
      step();
    end
    for (int k = 0; k < 300 && beats_done < 128; k++) step();
    n_cmp++; if (beats_done !== 128) begin n_fail++; $display("FAIL end_128_beats: got %0d want 128", beats_done); end
    hi = 0;
    repeat (10) begin step(); if (mem_req) hi++; end
    n_cmp++; if (hi !== 0) begin n_fail++; $display("FAIL end_done_no_req: got %0d req cycles want 0", hi); end
    n_cmp++; if (req_q.size() !== 8) begin n_fail++; $display("FAIL end_req_count: got %0d want 8", req_q.size()); end
    n_cmp++; if (req_q.size() < 8 || req_q[7] !== 25'h1070) begin n_fail++; $display("FAIL end_last_addr: got %h want 1070", req_q.size() < 8 ? 25'h0 : req_q[7]); end
    n_cmp++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL end_underflow: got %b want 0", underflow); end
  endtask
  task automatic test_underflow();
    held = read_data;
    read_sdram_en = 1'b1;
    step();
    read_sdram_en = 1'b0;
    n_cmp++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL uf_set: got %b want 1", underflow); end
    n_cmp++; if (read_data !== 32'd127) begin n_fail++; $display("FAIL uf_read_data: got %0d want 127", read_data); end
    n_cmp++; if (dut.count !== '0) begin n_fail++; $display("FAIL uf_count: got %0d want 0", dut.count); end
    repeat (3) step();
    n_cmp++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL uf_sticky: got %b want 1", underflow); end
    n_cmp++; if (read_data !== held) begin n_fail++; $display("FAIL uf_hold: got %0d want %0d", read_data, held); end
  endtask
  task automatic test_abort();
    beats_done = 0;
    frame_base = 25'h3000;
    newframe = 1'b1;
    step();
    newframe = 1'b0;
    n_cmp++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL abort_uf_cleared: got %b want 0", underflow); end
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 25'h3000) begin n_fail++; $display("FAIL abort_first_req: got %b/%h want 1/3000", mem_req, mem_addr); end
    for (int k = 0; k < 50 && beats_done < 5; k++) step();
    n_cmp++; if (beats_done !== 5) begin n_fail++; $display("FAIL abort_5_beats: got %0d want 5", beats_done); end
    frame_base = 25'h2000;
    newframe = 1'b1;
    step();
    newframe = 1'b0;
    n_cmp++; if (loading !== 1'b1) begin n_fail++; $display("FAIL abort_loading: got %b want 1", loading); end
    n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL abort_no_req: got %b want 0", mem_req); end
    hi = 0;
    for (int k = 0; k < 50 && beats_done < 16; k++) begin step(); if (mem_req) hi++; end
    n_cmp++; if (beats_done !== 16) begin n_fail++; $display("FAIL abort_16_beats: got %0d want 16", beats_done); end
    n_cmp++; if (hi !== 0) begin n_fail++; $display("FAIL abort_flush_no_req: got %0d req cycles want 0", hi); end
    n_cmp++; if (dut.count !== '0) begin n_fail++; $display("FAIL abort_fifo_empty: got %0d want 0", dut.count); end
    step();
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 25'h2000) begin n_fail++; $display("FAIL abort_new_req: got %b/%h want 1/2000", mem_req, mem_addr); end
    n_cmp++; if (dut.count !== '0) begin n_fail++; $display("FAIL abort_discarded: got %0d want 0", dut.count); end
  endtask
  initial begin
    reset = 1'b1;
    newframe = 1'b0;
    read_sdram_en = 1'b0;
    frame_base = '0;
    test_reset();
    test_prime();
    test_ordering();
    test_frame_end();
    test_underflow();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
